// File: rtl/emu_pkg.sv
// Shared types and constants for the emu_transactor block.
package emu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAP  = 2'd2
  } emu_state_e;

  localparam int BUSY_BIT   = 7;
  localparam int VALID_BIT  = 6;
  localparam int STEP_CNT_W = 9;

endpackage

// File: rtl/emu_transactor_if.sv
// Host byte bus of the transactor: write/command strobes in, read data and busy out.
interface emu_transactor_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]        Din_emu;
    logic [ADDR_W-1:0] Addr_emu;
    logic              wr_emu;
    logic              load_emu;
    logic              get_emu;
    logic              step_emu;
    logic [7:0]        Dout_emu;
    logic              busy_emu;

    modport master (
        output Din_emu, Addr_emu, wr_emu, load_emu, get_emu, step_emu,
        input  Dout_emu, busy_emu
    );

    modport slave (
        input  Din_emu, Addr_emu, wr_emu, load_emu, get_emu, step_emu,
        output Dout_emu, busy_emu
    );
endinterface

// File: rtl/emu_step_ctrl.sv
// Step-burst controller: counts N enabled DUT cycles, then optionally one capture cycle.
module emu_step_ctrl
    import emu_pkg::*;
#(
    parameter int AUTO_GET = 1
) (
    input  logic       clk_emu,
    input  logic       nreset_emu,
    input  logic       i_start,
    input  logic [7:0] i_cnt,
    output logic       o_dut_ce,
    output logic       o_busy,
    output logic       o_cap_pulse
);

    emu_state_e            r_state;
    emu_state_e            w_next;
    logic [STEP_CNT_W-1:0] r_cnt;
    logic [STEP_CNT_W-1:0] w_cnt_next;

    always_ff @(posedge clk_emu or negedge nreset_emu) begin
        if (!nreset_emu) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        o_dut_ce    = 1'b0;
        o_cap_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = RUN;
                    // A zero step count means a full 256-cycle burst.
                    w_cnt_next = (i_cnt == 8'd0) ? STEP_CNT_W'(256)
                                                 : {1'b0, i_cnt};
                end
            end
            RUN: begin
                o_dut_ce   = 1'b1;
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == STEP_CNT_W'(1))
                    w_next = (AUTO_GET != 0) ? CAP : IDLE;
            end
            CAP: begin
                o_cap_pulse = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/emu_transactor.sv
// Co-emulation transactor: stimulus/capture byte arrays, command decode and read mux.
// Optional EMU_MONITOR_EN adds clk_LED driven by a counter of enabled DUT cycles.
module emu_transactor
    import emu_pkg::*;
#(
    parameter int NUM_STIM = 2,
    parameter int NUM_OUT  = 2,
    parameter int ADDR_W   = 3,
    parameter int AUTO_GET = 1
) (
    input  logic                    clk_emu,
    input  logic                    nreset_emu,
    emu_transactor_if.slave         bus,
    output logic                    dut_ce,
    output logic [8*NUM_STIM-1:0]   dut_in,
`ifdef EMU_MONITOR_EN
    input  logic [8*NUM_OUT-1:0]    dut_out,
    output logic                    clk_LED
`else
    input  logic [8*NUM_OUT-1:0]    dut_out
`endif
);

    logic [NUM_STIM-1:0][7:0] r_stim;
    logic [NUM_STIM-1:0][7:0] r_applied;
    logic [NUM_OUT-1:0][7:0]  r_vect;
    logic                     r_cap_valid;
    logic [7:0]               r_dout;

    logic w_busy;
    logic w_cap_pulse;
    logic w_load;
    logic w_get;
    logic w_step;
    logic w_wr;
    logic w_capture;
    logic [7:0] w_status;
    logic [7:0] w_rd;

    // Only the highest-priority command acts, and only while idle.
    assign w_load    = !w_busy && bus.load_emu;
    assign w_get     = !w_busy && !bus.load_emu && bus.get_emu;
    assign w_step    = !w_busy && !bus.load_emu && !bus.get_emu && bus.step_emu;
    assign w_wr      = !w_busy && !bus.load_emu && !bus.get_emu && !bus.step_emu
                       && bus.wr_emu;
    assign w_capture = w_get || w_cap_pulse;

    emu_step_ctrl #(.AUTO_GET(AUTO_GET)) u_step_ctrl (
        .clk_emu     (clk_emu),
        .nreset_emu  (nreset_emu),
        .i_start     (w_step),
        .i_cnt       (bus.Din_emu),
        .o_dut_ce    (dut_ce),
        .o_busy      (w_busy),
        .o_cap_pulse (w_cap_pulse)
    );

    always_ff @(posedge clk_emu or negedge nreset_emu) begin
        if (!nreset_emu) begin
            r_stim    <= '0;
            r_applied <= '0;
        end else if (w_load) begin
            r_applied <= r_stim;
        end else if (w_wr) begin
            for (int k = 0; k < NUM_STIM; k++)
                if (bus.Addr_emu == ADDR_W'(k))
                    r_stim[k] <= bus.Din_emu;
        end
    end

    always_ff @(posedge clk_emu or negedge nreset_emu) begin
        if (!nreset_emu) begin
            r_vect      <= '0;
            r_cap_valid <= 1'b0;
        end else if (w_capture) begin
            r_vect      <= dut_out;
            r_cap_valid <= 1'b1;
        end else if (w_load) begin
            r_cap_valid <= 1'b0;
        end
    end

    always_comb begin
        w_status            = '0;
        w_status[BUSY_BIT]  = w_busy;
        w_status[VALID_BIT] = r_cap_valid;
    end

    // NUM_OUT never reaches the all-ones address, so vect and STATUS cannot overlap.
    always_comb begin
        w_rd = '0;
        if (&bus.Addr_emu)
            w_rd = w_status;
        for (int k = 0; k < NUM_OUT; k++)
            if (bus.Addr_emu == ADDR_W'(k))
                w_rd = r_vect[k];
    end

    always_ff @(posedge clk_emu or negedge nreset_emu) begin
        if (!nreset_emu) r_dout <= '0;
        else             r_dout <= w_rd;
    end

    assign bus.Dout_emu = r_dout;
    assign bus.busy_emu = w_busy;
    assign dut_in       = r_applied;

`ifdef EMU_MONITOR_EN
    logic [3:0] r_mon_cnt;

    always_ff @(posedge clk_emu or negedge nreset_emu) begin
        if (!nreset_emu)  r_mon_cnt <= '0;
        else if (dut_ce)  r_mon_cnt <= r_mon_cnt + 1'b1;
    end

    assign clk_LED = r_mon_cnt[3];
`endif

endmodule

// File: doc/emu_transactor.md
# emu_transactor

Parametrised co-emulation transactor for the Poorman's Standard-Emulator. It sits between the host byte bus and any DUT. It holds NUM_STIM stimulus bytes and NUM_OUT capture bytes, and applies stimulus to the DUT. It also generates a counted burst of DUT clock-enable cycles, so the host can advance the DUT N cycles per command instead of free-running it. Captured results and a status byte are read back over the same 8-bit bus.

## Interface
Parameters:
- NUM_STIM, 2: number of stimulus bytes, 1..(2^ADDR_W-1).
- NUM_OUT, 2: number of capture bytes, 1..(2^ADDR_W-1).
- ADDR_W, 3: host address width.
- AUTO_GET, 1: 1 = capture DUT outputs automatically at the end of a step burst.

Ports:
- clk_emu  in  1  single clock for transactor and DUT (DUT qualified by dut_ce).
- nreset_emu  in  1  asynchronous, active-low reset.
- Din_emu  in  8  host write data; also the step count for step_emu.
- Addr_emu  in  ADDR_W  host byte address.
- wr_emu  in  1  write Din_emu to stimulus byte Addr_emu.
- load_emu  in  1  transfer stimulus bytes to dut_in.
- get_emu  in  1  capture dut_out into the capture bytes.
- step_emu  in  1  start a burst of Din_emu DUT cycles (0 means 256).
- Dout_emu  out  8  registered read data.
- busy_emu  out  1  step burst or capture in progress.
- dut_ce  out  1  DUT clock enable.
- dut_in  out  8*NUM_STIM  stimulus; byte k is at bits [8k+7:8k].
- dut_out  in  8*NUM_OUT  DUT result; same byte packing.
- clk_LED  out  1  present only with EMU_MONITOR_EN.

## Operation
- Storage:
  - stim[0..NUM_STIM-1], applied[0..NUM_STIM-1] (drives dut_in) and vect[0..NUM_OUT-1].
  - All are zero on reset.
- Command priority per cycle: load_emu > get_emu > step_emu > wr_emu. Only the highest asserted command acts.
- Gating by state:
  - In IDLE, all commands act.
  - In RUN and CAP, load/get/step/wr are ignored (dropped, not queued).
  - Reads are always served.
- wr_emu: stim[Addr_emu] <= Din_emu if Addr_emu < NUM_STIM; otherwise no effect.
- load_emu: applied[k] <= stim[k] for all k.
- get_emu: vect[k] <= dut_out byte k for all k.
- Read, every cycle regardless of command:
  - Dout_emu <= vect[Addr_emu] if Addr_emu < NUM_OUT.
  - Dout_emu <= STATUS if Addr_emu == 2^ADDR_W-1.
  - Dout_emu <= 0 otherwise.
- STATUS = {busy_emu, capture_valid, 6'b0}. capture_valid sets on any capture and clears on load_emu.
- FSM states:
  - IDLE: step_emu (winning priority) loads cnt <= Din_emu (8-bit; 0 is treated as 256 by the 9-bit counter) and goes to RUN.
  - RUN: dut_ce=1 each cycle; cnt decrements; at cnt==1 go to CAP if AUTO_GET else IDLE.
  - CAP: vect <= dut_out, capture_valid <= 1, then go to IDLE.
- busy_emu = (state != IDLE).
- Mid-operation reset: state returns to IDLE, dut_ce drops to 0 immediately, and all registers are cleared.

## Timing
- Reset values: Dout_emu=0, busy_emu=0, dut_ce=0, dut_in=0, clk_LED=0.
- wr/load/get take effect at the sampling edge. dut_in is valid one cycle after load_emu.
- Read latency is 1 cycle: Dout_emu reflects the Addr_emu sampled at the previous edge.
- Step burst of N:
  - step_emu sampled at edge t.
  - dut_ce is high for exactly N cycles, edges t+1..t+N.
  - With AUTO_GET, capture happens at edge t+N+1 and busy_emu is high for N+1 cycles. Without it, busy_emu is high for N cycles.
- Captured data reflects the DUT state after its N-th enabled edge.
- A command asserted on the cycle busy_emu falls is ignored. A command on the following cycle is accepted.

## Configuration
- EMU_MONITOR_EN defined:
  - Adds the clk_LED port and a 4-bit counter that increments on each cycle with dut_ce=1.
  - clk_LED = counter[3]; counter resets to 0.
- EMU_MONITOR_EN undefined: no clk_LED port and no counter logic.

## Structure
- Shared package emu_pkg holds:
  - The state enum (IDLE, RUN, CAP).
  - STATUS bit positions (BUSY_BIT=7, VALID_BIT=6).
  - STEP_CNT_W=9.
- One sub-module: emu_step_ctrl. It contains the FSM, step counter, dut_ce and busy_emu, and outputs a one-cycle cap_pulse.
- Byte arrays and the read mux stay in the top.

## Test plan
- Reset mid-burst: start a burst with step 200, assert nreset_emu=0 at cycle 50 -> dut_ce=0, busy_emu=0 and Dout_emu=0 immediately; all arrays zero after release.
- Load, step, read with a counter DUT, NUM_STIM=2, NUM_OUT=2:
  - Stimulus: wr 0x12 to addr 0, wr 0x01 to addr 1, load, step 5, read addrs 0 and 1.
  - Required: dut_ce high exactly 5 cycles; busy 6 cycles; vect = counter+5; STATUS=0x40 after completion.
- Step zero: step_emu with Din_emu=0 -> 256 dut_ce cycles, then capture.
- Priority and busy-drop:
  - load and wr in the same cycle -> stim is unchanged.
  - step while busy -> ignored, with no extension of the burst.
  - wr while busy -> stim is unchanged.
- Out-of-range address: wr to addr 5 with NUM_STIM=2 -> no change. Read addr 5 -> 0x00. Read addr 7 -> STATUS.
- AUTO_GET=0:
  - step 3 -> busy 3 cycles, vect unchanged, STATUS=0x00.
  - Then get_emu -> vect updated, STATUS=0x40.
